fib_monitor: RTL and testbench

- Downstream consumer of the fibonacci generator's WIDTH-bit value bus.
- Runs on wb_clk_i and samples the value bus, which changes on a divided clock.
- Detects each new term, keeps the last two terms and a term count, and flags threshold crossings and sequence wrap/restart.
- Exposes these as Wishbone-readable registers and drives a level interrupt.

---
 rtl/fib_pkg.sv | 49 ++++
 rtl/fib_monitor_if.sv | 26 ++
 rtl/fib_sample_sync.sv | 38 +++
 rtl/fib_monitor.sv | 144 ++++++++++++++
 tb/tb_fib_monitor.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/fib_pkg.sv
// Shared constants for the fibonacci monitor: register map, bit positions,
// reset values, bus FSM states and a byte-lane merge helper.
package fib_pkg;

    localparam int unsigned BUS_W  = 32;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned CTRL_W = 3;
    localparam int unsigned STAT_W = 2;

    // Register offsets within the 256-byte window
    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_LAST   = 8'h08;
    localparam logic [7:0] OFF_PREV   = 8'h0C;
    localparam logic [7:0] OFF_COUNT  = 8'h10;
    localparam logic [7:0] OFF_THRESH = 8'h14;

    // CTRL bits
    localparam int unsigned CTRL_THR_IRQ_EN  = 0;
    localparam int unsigned CTRL_WRAP_IRQ_EN = 1;
    localparam int unsigned CTRL_COUNT_EN    = 2;

    // STATUS bits
    localparam int unsigned STATUS_THR  = 0;
    localparam int unsigned STATUS_WRAP = 1;

    // Counting enabled, interrupts disabled
    localparam logic [CTRL_W-1:0] CTRL_RST = 3'b100;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } wb_state_e;

    // Merge write data into an existing word, one byte per asserted select
    function automatic logic [BUS_W-1:0] apply_sel(
        input logic [BUS_W-1:0] old_val,
        input logic [BUS_W-1:0] wdata,
        input logic [SEL_W-1:0] sel
    );
        logic [BUS_W-1:0] res;
        res = old_val;
        for (int i = 0; i < int'(SEL_W); i++) begin
            if (sel[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/fib_monitor_if.sv
// Wishbone slave bus bundle for the fibonacci monitor.
//   wbs_stb_i/cyc_i/we_i/sel_i/dat_i/adr_i : request from master
//   wbs_ack_o/dat_o                        : response from slave
interface fib_monitor_if;
    import fib_pkg::*;

    logic             wbs_stb_i;
    logic             wbs_cyc_i;
    logic             wbs_we_i;
    logic [SEL_W-1:0] wbs_sel_i;
    logic [BUS_W-1:0] wbs_dat_i;
    logic [BUS_W-1:0] wbs_adr_i;
    logic             wbs_ack_o;
    logic [BUS_W-1:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/fib_sample_sync.sv
// Two-flop sampler for the slow fibonacci value bus plus new-term detection.
//   clk, reset : system clock, synchronous active-high reset
//   value_in   : raw value bus (changes on a divided clock)
//   last       : most recently accepted term
//   count_en   : detection enable
//   sample     : second sync stage (candidate value)
//   new_term   : one-cycle pulse when a stable, different value is seen
module fib_sample_sync #(
    parameter int unsigned WIDTH = 30
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] value_in,
    input  logic [WIDTH-1:0] last,
    input  logic             count_en,
    output logic [WIDTH-1:0] sample,
    output logic             new_term
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    // Synchroniser stages
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= value_in;
            s2_q <= s1_q;
        end
    end

    // Pulse is naturally one cycle: LAST takes s2 on the same edge it is consumed
    assign sample   = s2_q;
    assign new_term = (s1_q == s2_q) && (s2_q != last) && count_en;

endmodule

// File: rtl/fib_monitor.sv
// Fibonacci value-bus monitor: tracks the last two terms and a term count,
// flags threshold crossings and wraps, and exposes them over Wishbone.
//   wb_clk_i, reset : system clock, synchronous active-high reset
//   value_in        : fibonacci value bus
//   wbs             : Wishbone slave port
//   irq_out         : level interrupt
module fib_monitor
    import fib_pkg::*;
#(
    parameter int unsigned WIDTH     = 30,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
    input  logic             wb_clk_i,
    input  logic             reset,
    input  logic [WIDTH-1:0] value_in,
    fib_monitor_if.slave     wbs,
    output logic             irq_out
);

    wb_state_e         state_q, state_d;
    logic [CTRL_W-1:0] ctrl_q;
    logic [STAT_W-1:0] status_q;
    logic [WIDTH-1:0]  last_q;
    logic [WIDTH-1:0]  prev_q;
    logic [BUS_W-1:0]  count_q;
    logic [WIDTH-1:0]  thresh_q;
    logic [BUS_W-1:0]  dat_q;
    logic              irq_q;

    logic [WIDTH-1:0]  sample;
    logic              new_term;
    logic [7:0]        off;
    logic              hit;
    logic              req;
    logic              wr_fire;
    logic [BUS_W-1:0]  rd_data;
    logic [STAT_W-1:0] set_flags;
    logic [STAT_W-1:0] w1c;

    fib_sample_sync #(.WIDTH(WIDTH)) u_sync (
        .clk      (wb_clk_i),
        .reset    (reset),
        .value_in (value_in),
        .last     (last_q),
        .count_en (ctrl_q[CTRL_COUNT_EN]),
        .sample   (sample),
        .new_term (new_term)
    );

    assign off     = wbs.wbs_adr_i[7:0];
    assign hit     = (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign req     = wbs.wbs_stb_i && wbs.wbs_cyc_i && hit;
    assign wr_fire = (state_q == ST_ACK) && req && wbs.wbs_we_i;

    // Bus FSM state register
    always_ff @(posedge wb_clk_i) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Bus FSM next state: ACK always returns to IDLE, so acks are at most every other cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req) state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Read mux
    always_comb begin
        rd_data = '0;
        case (off)
            OFF_CTRL:   rd_data = BUS_W'(ctrl_q);
            OFF_STATUS: rd_data = BUS_W'(status_q);
            OFF_LAST:   rd_data = BUS_W'(last_q);
            OFF_PREV:   rd_data = BUS_W'(prev_q);
            OFF_COUNT:  rd_data = count_q;
            OFF_THRESH: rd_data = BUS_W'(thresh_q);
            default:    rd_data = '0;
        endcase
    end

    // Flag sets from the incoming term and write-1-to-clear mask
    always_comb begin
        set_flags = '0;
        w1c       = '0;
        if (new_term) begin
            set_flags[STATUS_WRAP] = (sample < last_q);
            set_flags[STATUS_THR]  = (thresh_q != '0) && (sample >= thresh_q);
        end
        if (wr_fire && (off == OFF_STATUS) && wbs.wbs_sel_i[0]) begin
            w1c = wbs.wbs_dat_i[STAT_W-1:0];
        end
    end

    // Register file, read data and interrupt
    always_ff @(posedge wb_clk_i) begin
        if (reset) begin
            ctrl_q   <= CTRL_RST;
            status_q <= '0;
            last_q   <= '0;
            prev_q   <= '0;
            count_q  <= '0;
            thresh_q <= '0;
            dat_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (new_term) begin
                prev_q <= last_q;
                last_q <= sample;
            end

            // A clear landing with a new term leaves exactly that term counted
            if (wr_fire && (off == OFF_COUNT) && (wbs.wbs_sel_i != '0)) begin
                count_q <= new_term ? BUS_W'(1) : '0;
            end else if (new_term) begin
                count_q <= count_q + BUS_W'(1);
            end

            // Set wins over a simultaneous clear
            status_q <= (status_q & ~w1c) | set_flags;

            if (wr_fire && (off == OFF_CTRL) && wbs.wbs_sel_i[0]) begin
                ctrl_q <= wbs.wbs_dat_i[CTRL_W-1:0];
            end

            if (wr_fire && (off == OFF_THRESH)) begin
                thresh_q <= WIDTH'(apply_sel(BUS_W'(thresh_q), wbs.wbs_dat_i, wbs.wbs_sel_i));
            end

            dat_q <= ((state_q == ST_IDLE) && req) ? rd_data : '0;

            irq_q <= (status_q[STATUS_THR]  && ctrl_q[CTRL_THR_IRQ_EN]) ||
                     (status_q[STATUS_WRAP] && ctrl_q[CTRL_WRAP_IRQ_EN]);
        end
    end

    assign wbs.wbs_ack_o = (state_q == ST_ACK);
    assign wbs.wbs_dat_o = dat_q;
    assign irq_out       = irq_q;

endmodule

// File: tb/tb_fib_monitor.sv
// Directed bench for fib_monitor with a read-data scoreboard.
module tb_fib_monitor;
    import fib_pkg::*;

    localparam int unsigned WIDTH = 30;
    localparam logic [31:0] BASE  = 32'h3000_0100;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] value_in;
    logic             irq_out;

    fib_monitor_if wb ();

    fib_monitor #(.WIDTH(WIDTH), .BASE_ADDR(BASE)) dut (
        .wb_clk_i (clk),
        .reset    (reset),
        .value_in (value_in),
        .wbs      (wb.slave),
        .irq_out  (irq_out)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [WIDTH-1:0] v, input int n);
        value_in = v;
        step(n);
    endtask

    task automatic bus_idle();
        wb.wbs_stb_i = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = '0;
        wb.wbs_dat_i = '0;
        wb.wbs_adr_i = '0;
    endtask

    // Single transfer; bus held through the ack cycle so writes land on its closing edge
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic got, output logic [31:0] rdata);
        int lat;
        got   = 1'b0;
        rdata = '0;
        lat   = 0;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_we_i  = we;
        wb.wbs_adr_i = adr;
        wb.wbs_dat_i = dat;
        wb.wbs_sel_i = sel;
        while (!got && lat < 16) begin
            step(1);
            lat++;
            if (wb.wbs_ack_o) begin
                got   = 1'b1;
                rdata = wb.wbs_dat_o;
            end
        end
        if (got) begin
            check("ack_latency", 32'(lat), 32'd1);
            step(1);
        end
        bus_idle();
        if (got) begin
            check("ack_width", 32'(wb.wbs_ack_o), 32'd0);
            check("dat_idle", wb.wbs_dat_o, 32'd0);
        end
    endtask

    task automatic wb_read(input logic [7:0] off, input logic [31:0] exp, input string tag);
        logic        got;
        logic [31:0] rd;
        logic [31:0] e;
        sb.push_back(exp);
        wb_xfer(1'b0, BASE + 32'(off), 32'd0, 4'hF, got, rd);
        check({tag, "_ack"}, 32'(got), 32'd1);
        e = sb.pop_front();
        check(tag, rd, e);
    endtask

    task automatic wb_write(input logic [7:0] off, input logic [31:0] dat, input logic [3:0] sel);
        logic        got;
        logic [31:0] rd;
        wb_xfer(1'b1, BASE + 32'(off), dat, sel, got, rd);
        check("wr_ack", 32'(got), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        got;
        logic [31:0] rd;

        // Reset and register defaults
        bus_idle();
        reset    = 1'b1;
        value_in = '0;
        step(3);
        check("rst_irq", 32'(irq_out), 32'd0);
        check("rst_ack", 32'(wb.wbs_ack_o), 32'd0);
        check("rst_dat", wb.wbs_dat_o, 32'd0);
        reset = 1'b0;
        step(1);
        wb_read(OFF_CTRL,   32'd4, "rst_ctrl");
        wb_read(OFF_STATUS, 32'd0, "rst_status");
        wb_read(OFF_LAST,   32'd0, "rst_last");
        wb_read(OFF_PREV,   32'd0, "rst_prev");
        wb_read(OFF_COUNT,  32'd0, "rst_count");
        wb_read(OFF_THRESH, 32'd0, "rst_thresh");

        // Basic sequence; initial 0 and the repeated 1 do not count
        hold(0, 8); hold(1, 8); hold(1, 8); hold(2, 8); hold(3, 8); hold(5, 8);
        wb_read(OFF_COUNT,  32'd4, "seq_count");
        wb_read(OFF_LAST,   32'd5, "seq_last");
        wb_read(OFF_PREV,   32'd3, "seq_prev");
        wb_read(OFF_STATUS, 32'd0, "seq_status");

        // Threshold crossing and interrupt timing
        wb_write(OFF_THRESH, 32'd8, 4'hF);
        wb_write(OFF_CTRL,   32'd5, 4'hF);
        hold(5, 8);
        value_in = 8;
        step(3);
        check("thr_irq_early", 32'(irq_out), 32'd0);
        step(1);
        check("thr_irq", 32'(irq_out), 32'd1);
        step(6);
        wb_read(OFF_STATUS, 32'd1, "thr_status");
        wb_read(OFF_COUNT,  32'd5, "thr_count");
        wb_read(OFF_LAST,   32'd8, "thr_last");
        wb_read(OFF_PREV,   32'd5, "thr_prev");
        wb_write(OFF_STATUS, 32'd1, 4'hF);
        check("thr_irq_lag", 32'(irq_out), 32'd1);
        step(1);
        check("thr_irq_clr", 32'(irq_out), 32'd0);
        wb_read(OFF_STATUS, 32'd0, "thr_status_clr");

        // Wrap detection
        wb_write(OFF_CTRL, 32'd6, 4'hF);
        hold(13, 8);
        hold(0, 8);
        check("wrap_irq", 32'(irq_out), 32'd1);
        wb_read(OFF_STATUS, 32'd3, "wrap_status");
        wb_read(OFF_COUNT,  32'd7, "wrap_count");
        wb_read(OFF_PREV,   32'd13, "wrap_prev");
        hold(21, 8);
        // W1C of both flags on the same edge as a new wrap: wrap survives
        value_in = 1;
        step(1);
        wb_write(OFF_STATUS, 32'd3, 4'hF);
        step(6);
        wb_read(OFF_STATUS, 32'd2, "w1c_race_status");
        wb_read(OFF_COUNT,  32'd9, "w1c_race_count");
        wb_read(OFF_LAST,   32'd1, "w1c_race_last");
        wb_read(OFF_PREV,   32'd21, "w1c_race_prev");
        check("w1c_race_irq", 32'(irq_out), 32'd1);
        // COUNT clear on the same edge as a new term leaves 1
        value_in = 2;
        step(1);
        wb_write(OFF_COUNT, 32'd0, 4'hF);
        step(6);
        wb_read(OFF_COUNT, 32'd1, "clr_race_count");
        wb_read(OFF_LAST,  32'd2, "clr_race_last");

        // Counting disabled, COUNT clear, holes and out-of-window
        wb_write(OFF_CTRL, 32'd0, 4'hF);
        hold(21, 8);
        wb_read(OFF_LAST,  32'd2, "frz_last");
        wb_read(OFF_COUNT, 32'd1, "frz_count");
        check("frz_irq", 32'(irq_out), 32'd0);
        wb_write(OFF_COUNT, 32'd0, 4'h1);
        wb_read(OFF_COUNT, 32'd0, "cnt_clr");
        wb_write(OFF_THRESH, 32'hFFFF_FF33, 4'h1);
        wb_read(OFF_THRESH, 32'd51, "thresh_lane");
        wb_read(8'h20, 32'd0, "hole");
        wb_xfer(1'b0, BASE + 32'h100, 32'd0, 4'hF, got, rd);
        check("outside_noack", 32'(got), 32'd0);

        // Reset while an ack is pending
        wb.wbs_stb_i = 1'b1;
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = 4'hF;
        wb.wbs_adr_i = BASE + 32'(OFF_LAST);
        step(1);
        check("pend_ack", 32'(wb.wbs_ack_o), 32'd1);
        reset    = 1'b1;
        value_in = '0;
        step(1);
        check("rst_mid_ack", 32'(wb.wbs_ack_o), 32'd0);
        check("rst_mid_dat", wb.wbs_dat_o, 32'd0);
        bus_idle();
        step(1);
        reset = 1'b0;
        step(1);
        check("rst_mid_irq", 32'(irq_out), 32'd0);
        wb_read(OFF_CTRL,   32'd4, "rst2_ctrl");
        wb_read(OFF_STATUS, 32'd0, "rst2_status");
        wb_read(OFF_LAST,   32'd0, "rst2_last");
        wb_read(OFF_PREV,   32'd0, "rst2_prev");
        wb_read(OFF_COUNT,  32'd0, "rst2_count");
        wb_read(OFF_THRESH, 32'd0, "rst2_thresh");

        // Input changing every cycle never looks stable
        for (int i = 1; i <= 10; i++) begin
            value_in = WIDTH'(i);
            step(1);
        end
        hold(0, 8);
        wb_read(OFF_COUNT, 32'd0, "glitch_count");
        wb_read(OFF_LAST,  32'd0, "glitch_last");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
